row_line_decoder: RTL and testbench

Registered 3-to-8 one-hot line decoder with enable. It drives the row-select lines of the 8x8 RGB LED matrix scanner. A 3-bit row index plus enable becomes an 8-bit one-hot row-drive vector; output polarity is selectable. A status index/flag is provided for the scan controller. An optional break-before-make gap can be compiled in to suppress ghosting between rows.

---
 rtl/row_line_pkg.sv | 30 +++
 rtl/row_line_decoder.sv | 123 ++++++++++++
 tb/tb_row_line_decoder.sv | 124 ++++++++++++
 3 files changed

// File: rtl/row_line_pkg.sv
// rtl/row_line_pkg.sv - shared widths, state enum and one-hot helper for the row line decoder
package row_line_pkg;

  localparam int SEL_W    = 3;
  localparam int LINE_NUM = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } line_state_e;

  // Active-high one-hot; the full case keeps X off the row lines.
  function automatic logic [LINE_NUM-1:0] onehot8(input logic [SEL_W-1:0] idx);
    logic [LINE_NUM-1:0] oh;
    case (idx)
      3'd0:    oh = 8'h01;
      3'd1:    oh = 8'h02;
      3'd2:    oh = 8'h04;
      3'd3:    oh = 8'h08;
      3'd4:    oh = 8'h10;
      3'd5:    oh = 8'h20;
      3'd6:    oh = 8'h40;
      3'd7:    oh = 8'h80;
      default: oh = 8'h00;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/row_line_decoder.sv
// rtl/row_line_decoder.sv - registered 3-to-8 one-hot row-select decoder with enable
//
// Purpose: drives the row-select lines of the 8x8 LED matrix scanner.
// Optional break-before-make gap: define ROW_LINE_DECODER_DEADTIME_EN.
// Ports:
//   clk_i         system clock, rising edge
//   rst_i         synchronous active-high reset
//   data_3bit_i   requested line index 0..7
//   decoder_en_i  1 = drive requested line, 0 = all lines off
//   data_8bit_o   registered line drive, polarity per ACTIVE_HIGH
//   active_o      registered, 1 when one line is driven
//   active_idx_o  registered index of driven line, 0 when idle
module row_line_decoder
  import row_line_pkg::*;
#(
  parameter bit          ACTIVE_HIGH  = 1'b1,
  parameter int unsigned DEADTIME_CYC = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [SEL_W-1:0]    data_3bit_i,
  input  logic                decoder_en_i,
  output logic [LINE_NUM-1:0] data_8bit_o,
  output logic                active_o,
  output logic [SEL_W-1:0]    active_idx_o
);

  localparam logic [LINE_NUM-1:0] LINES_OFF = ACTIVE_HIGH ? 8'h00 : 8'hFF;

  if (DEADTIME_CYC < 1 || DEADTIME_CYC > 15) begin : g_bad_deadtime
    $error("row_line_decoder: DEADTIME_CYC out of range 1..15");
  end

  logic [LINE_NUM-1:0] r_drive;
  logic                r_active;
  logic [SEL_W-1:0]    r_active_idx;
  logic [LINE_NUM-1:0] w_line_drive;

  // Polarity is applied only on the way into the output register.
  assign w_line_drive = ACTIVE_HIGH ? onehot8(data_3bit_i) : ~onehot8(data_3bit_i);

`ifdef ROW_LINE_DECODER_DEADTIME_EN
  localparam logic [3:0] GAP_LEN = 4'(DEADTIME_CYC);

  line_state_e r_state;
  logic [3:0]  r_gap_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_gap_cnt    <= 4'd0;
      r_drive      <= LINES_OFF;
      r_active     <= 1'b0;
      r_active_idx <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (decoder_en_i) begin
            r_state      <= ST_DRIVE;
            r_drive      <= w_line_drive;
            r_active     <= 1'b1;
            r_active_idx <= data_3bit_i;
          end
        end
        ST_DRIVE: begin
          if (!decoder_en_i) begin
            r_state      <= ST_IDLE;
            r_drive      <= LINES_OFF;
            r_active     <= 1'b0;
            r_active_idx <= '0;
          end else if (data_3bit_i != r_active_idx) begin
            // This edge is the first all-off cycle of the gap.
            r_state      <= ST_GAP;
            r_gap_cnt    <= 4'd1;
            r_drive      <= LINES_OFF;
            r_active     <= 1'b0;
            r_active_idx <= '0;
          end
        end
        ST_GAP: begin
          if (!decoder_en_i) begin
            r_state   <= ST_IDLE;
            r_gap_cnt <= 4'd0;
          end else if (r_gap_cnt >= GAP_LEN) begin
            // Index changes during the gap do not restart it; take the latest.
            r_state      <= ST_DRIVE;
            r_gap_cnt    <= 4'd0;
            r_drive      <= w_line_drive;
            r_active     <= 1'b1;
            r_active_idx <= data_3bit_i;
          end else begin
            r_gap_cnt <= r_gap_cnt + 4'd1;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_gap_cnt    <= 4'd0;
          r_drive      <= LINES_OFF;
          r_active     <= 1'b0;
          r_active_idx <= '0;
        end
      endcase
    end
  end
`else
  always_ff @(posedge clk_i) begin
    if (rst_i || !decoder_en_i) begin
      r_drive      <= LINES_OFF;
      r_active     <= 1'b0;
      r_active_idx <= '0;
    end else begin
      r_drive      <= w_line_drive;
      r_active     <= 1'b1;
      r_active_idx <= data_3bit_i;
    end
  end
`endif

  assign data_8bit_o  = r_drive;
  assign active_o     = r_active;
  assign active_idx_o = r_active_idx;

endmodule

// File: tb/tb_row_line_decoder.sv
// tb/tb_row_line_decoder.sv - table-driven self-checking bench for row_line_decoder
module tb_row_line_decoder;

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] idx;
    logic [7:0] exp_data;
    logic       exp_act;
    logic [2:0] exp_idx;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] idx;
  logic [7:0] data_hi, data_lo;
  logic       act_hi, act_lo;
  logic [2:0] aidx_hi, aidx_lo;

  int errors = 0;
  int checks = 0;
  vec_t vecs[$];

  always #10 clk = ~clk;

  row_line_decoder #(.ACTIVE_HIGH(1'b1), .DEADTIME_CYC(2)) u_dut_hi (
    .clk_i(clk), .rst_i(rst), .data_3bit_i(idx), .decoder_en_i(en),
    .data_8bit_o(data_hi), .active_o(act_hi), .active_idx_o(aidx_hi)
  );

  row_line_decoder #(.ACTIVE_HIGH(1'b0), .DEADTIME_CYC(2)) u_dut_lo (
    .clk_i(clk), .rst_i(rst), .data_3bit_i(idx), .decoder_en_i(en),
    .data_8bit_o(data_lo), .active_o(act_lo), .active_idx_o(aidx_lo)
  );

  task automatic chk(input string name, input int step, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, step, act, req);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic [2:0] i,
                     input logic [7:0] d, input logic a, input logic [2:0] ai);
    vec_t v;
    v.rst = r; v.en = e; v.idx = i;
    v.exp_data = d; v.exp_act = a; v.exp_idx = ai;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; idx = 3'd5;

    // Two reset cycles with enable high, then release: line 5 one cycle later.
    add(1, 1, 3'd5, 8'h00, 0, 3'd0);
    add(1, 1, 3'd5, 8'h00, 0, 3'd0);
    add(0, 1, 3'd5, 8'h20, 1, 3'd5);
`ifdef ROW_LINE_DECODER_DEADTIME_EN
    // Steady line 2, change to 3: two all-off cycles, then line 3.
    add(0, 0, 3'd2, 8'h00, 0, 3'd0);
    add(0, 1, 3'd2, 8'h04, 1, 3'd2);
    add(0, 1, 3'd2, 8'h04, 1, 3'd2);
    add(0, 1, 3'd3, 8'h00, 0, 3'd0);
    add(0, 1, 3'd3, 8'h00, 0, 3'd0);
    add(0, 1, 3'd3, 8'h08, 1, 3'd3);
    // Change to 4, then 5 mid-gap: gap not extended, latest index wins.
    add(0, 1, 3'd4, 8'h00, 0, 3'd0);
    add(0, 1, 3'd5, 8'h00, 0, 3'd0);
    add(0, 1, 3'd5, 8'h20, 1, 3'd5);
    // Enable drop leaves at once; re-enable from idle has no gap.
    add(0, 0, 3'd5, 8'h00, 0, 3'd0);
    add(0, 1, 3'd1, 8'h02, 1, 3'd1);
    // Enable drop mid-gap returns to idle; next enable drives directly.
    add(0, 1, 3'd2, 8'h00, 0, 3'd0);
    add(0, 0, 3'd2, 8'h00, 0, 3'd0);
    add(0, 1, 3'd2, 8'h04, 1, 3'd2);
    // Wrap 7 -> 0 also goes through the gap.
    add(0, 1, 3'd7, 8'h00, 0, 3'd0);
    add(0, 1, 3'd7, 8'h00, 0, 3'd0);
    add(0, 1, 3'd7, 8'h80, 1, 3'd7);
    add(0, 1, 3'd0, 8'h00, 0, 3'd0);
    // Reset mid-gap: idle, and the next line appears without a gap.
    add(1, 1, 3'd0, 8'h00, 0, 3'd0);
    add(0, 1, 3'd6, 8'h40, 1, 3'd6);
    add(0, 1, 3'd6, 8'h40, 1, 3'd6);
`else
    // Sweep 0..7, then wrap back to 0.
    for (int i = 0; i < 8; i++) add(0, 1, 3'(i), 8'h01 << i, 1, 3'(i));
    add(0, 1, 3'd0, 8'h01, 1, 3'd0);
    // Enable gating on line 3, then hold.
    add(0, 1, 3'd3, 8'h08, 1, 3'd3);
    add(0, 0, 3'd3, 8'h00, 0, 3'd0);
    add(0, 1, 3'd3, 8'h08, 1, 3'd3);
    add(0, 1, 3'd3, 8'h08, 1, 3'd3);
    // Line 6, disable, re-enable.
    add(0, 1, 3'd6, 8'h40, 1, 3'd6);
    add(0, 0, 3'd6, 8'h00, 0, 3'd0);
    add(0, 1, 3'd6, 8'h40, 1, 3'd6);
`endif
    // Reset wins over an active enable.
    add(1, 1, 3'd6, 8'h00, 0, 3'd0);

    for (int k = 0; k < vecs.size(); k++) begin
      rst = vecs[k].rst;
      en  = vecs[k].en;
      idx = vecs[k].idx;
      @(posedge clk);
      #1;
      chk("data_hi", k, data_hi, vecs[k].exp_data);
      chk("active_hi", k, {7'd0, act_hi}, {7'd0, vecs[k].exp_act});
      chk("idx_hi", k, {5'd0, aidx_hi}, {5'd0, vecs[k].exp_idx});
      chk("data_lo", k, data_lo, ~vecs[k].exp_data);
      chk("active_lo", k, {7'd0, act_lo}, {7'd0, vecs[k].exp_act});
      chk("idx_lo", k, {5'd0, aidx_lo}, {5'd0, vecs[k].exp_idx});
      chk("onehot_hi", k, {7'd0, ($countones(data_hi) > 1)}, 8'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
